// File: rtl/clk_period_meter_if.sv
// clk_period_meter_if
//   Groups the measurement control input, the signal under test and the
//   measurement results of clk_period_meter into one bundle.
//
//   master : the stimulus/consumer side (drives en, sig_in; reads results)
//   slave  : the meter itself (reads en, sig_in; drives results)
//
//   en           measurement enable
//   sig_in       clock-like signal to measure, asynchronous to ref_clock
//   period       last measured period in ref_clock cycles
//   high_time    high cycles within the last period (0 without the duty option)
//   period_valid one-cycle strobe when period/high_time update
//   locked       two consecutive equal periods seen
//   timeout      sticky: no rising edge within the timeout window
interface clk_period_meter_if #(
    parameter int WIDTH = 32
);
    logic             en;
    logic             sig_in;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] high_time;
    logic             period_valid;
    logic             locked;
    logic             timeout;

    modport master (
        output en, sig_in,
        input  period, high_time, period_valid, locked, timeout
    );

    modport slave (
        input  en, sig_in,
        output period, high_time, period_valid, locked, timeout
    );
endinterface

// File: rtl/clk_period_meter.sv
// clk_period_meter
//   Recovers the period (divisor) of a clock-like signal in ref_clock cycles.
//   sig_in is synchronized, rising edges are detected, and the number of
//   ref_clock posedges between consecutive rises is reported with a
//   one-cycle period_valid strobe. locked means the last two completed
//   periods matched; timeout is sticky and set when no rise arrives within
//   TIMEOUT cycles of the previous one.
//
//   Optional feature: define CLK_METER_DUTY_EN to count high cycles per
//   period into high_time. Without it the high counter is absent and
//   high_time is tied to 0.
//
//   Ports:
//     ref_clock  sole clock, posedge
//     rst        synchronous, active-high reset
//     bus        clk_period_meter_if.slave (en, sig_in in; results out)
//
//   Parameters:
//     WIDTH        counter / result width
//     SYNC_STAGES  synchronizer depth on sig_in (>= 2)
//     TIMEOUT      cycles without a rise before abort (2 .. 2^WIDTH-1)
module clk_period_meter #(
    parameter int          WIDTH       = 32,
    parameter int          SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 32'hFFFF_FFFF
) (
    input  logic              ref_clock,
    input  logic              rst,
    clk_period_meter_if.slave bus
);
    localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_e;

    state_e                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d_q;
    logic [WIDTH-1:0]       cnt_q;
    // Previous completed period; 0 means "none yet" since a real period is >= 2.
    logic [WIDTH-1:0]       prev_q;
    logic [WIDTH-1:0]       period_q;
    logic                   valid_q;
    logic                   locked_q;
    logic                   timeout_q;
`ifdef CLK_METER_DUTY_EN
    logic [WIDTH-1:0]       hcnt_q;
    logic [WIDTH-1:0]       high_q;
`endif

    logic s;
    logic rise;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d_q;

    always_ff @(posedge ref_clock) begin
        if (rst) begin
            state_q   <= IDLE;
            sync_q    <= '0;
            s_d_q     <= 1'b0;
            cnt_q     <= '0;
            prev_q    <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
`ifdef CLK_METER_DUTY_EN
            hcnt_q    <= '0;
            high_q    <= '0;
`endif
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.sig_in};
            s_d_q   <= s;
            valid_q <= 1'b0;

            if (!bus.en) begin
                // Discard the partial measurement; results hold, lock drops.
                state_q  <= IDLE;
                cnt_q    <= '0;
                prev_q   <= '0;
                locked_q <= 1'b0;
`ifdef CLK_METER_DUTY_EN
                hcnt_q   <= '0;
`endif
            end else begin
                case (state_q)
                    IDLE: begin
                        if (rise) begin
                            state_q <= MEASURE;
                            cnt_q   <= WIDTH'(1);
`ifdef CLK_METER_DUTY_EN
                            hcnt_q  <= WIDTH'(1);
`endif
                        end else begin
                            cnt_q   <= '0;
`ifdef CLK_METER_DUTY_EN
                            hcnt_q  <= '0;
`endif
                        end
                    end
                    MEASURE: begin
                        // A rise on the TIMEOUT cycle still completes a period.
                        if (rise) begin
                            period_q  <= cnt_q;
                            valid_q   <= 1'b1;
                            timeout_q <= 1'b0;
                            locked_q  <= (cnt_q == prev_q);
                            prev_q    <= cnt_q;
                            cnt_q     <= WIDTH'(1);
`ifdef CLK_METER_DUTY_EN
                            high_q    <= hcnt_q;
                            hcnt_q    <= WIDTH'(1);
`endif
                        end else if (cnt_q == TIMEOUT_W) begin
                            state_q   <= IDLE;
                            timeout_q <= 1'b1;
                            locked_q  <= 1'b0;
                            prev_q    <= '0;
                            cnt_q     <= '0;
`ifdef CLK_METER_DUTY_EN
                            hcnt_q    <= '0;
`endif
                        end else begin
                            cnt_q     <= cnt_q + WIDTH'(1);
`ifdef CLK_METER_DUTY_EN
                            hcnt_q    <= hcnt_q + {{(WIDTH-1){1'b0}}, s};
`endif
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.period       = period_q;
    assign bus.period_valid = valid_q;
    assign bus.locked       = locked_q;
    assign bus.timeout      = timeout_q;
`ifdef CLK_METER_DUTY_EN
    assign bus.high_time    = high_q;
`else
    assign bus.high_time    = '0;
`endif

endmodule

// File: tb/tb_clk_period_meter.sv
// Bench for clk_period_meter (TIMEOUT=20, SYNC_STAGES=2). A reference model
// works on absolute cycle indices of the delayed signal: period is the
// distance between rises, high time is the sum of recorded samples.
module tb_clk_period_meter;
    localparam int W  = 32;
    localparam int SS = 2;
    localparam int TO = 20;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    clk_period_meter_if #(.WIDTH(W)) bus();

    clk_period_meter #(.WIDTH(W), .SYNC_STAGES(SS), .TIMEOUT(TO)) dut (
        .ref_clock (clk),
        .rst       (rst),
        .bus       (bus.slave)
    );

    int vecs = 0;
    int errs = 0;
    int pv_cnt = 0;
    logic en_cur;

    // reference model state
    int        t = 0;
    logic [SS-1:0] m_sq;
    logic      m_sd;
    logic      s_hist [0:16383];
    int        m_last, m_prev, m_period, m_high;
    logic      m_armed, m_pv, m_locked, m_timeout;

    typedef struct {
        int   p;
        int   h;
        int   n;
        logic [31:0] exp_period;
        logic [31:0] exp_high;
        logic        exp_locked;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, t, act, exp);
        end
    endtask

    task automatic model_step();
        logic s, rise;
        s    = m_sq[SS-1];
        rise = s & ~m_sd;
        if (rst) begin
            m_sq = '0; m_sd = 1'b0; m_armed = 1'b0; m_prev = 0;
            m_period = 0; m_high = 0; m_pv = 1'b0; m_locked = 1'b0; m_timeout = 1'b0;
            s = 1'b0;
        end else begin
            m_pv = 1'b0;
            if (!bus.en) begin
                m_armed = 1'b0; m_prev = 0; m_locked = 1'b0;
            end else if (rise) begin
                if (m_armed) begin
                    m_period = t - m_last;
                    m_high = 0;
                    for (int k = m_last; k < t; k++) m_high += int'(s_hist[k]);
                    m_pv = 1'b1;
                    m_locked = (m_prev == m_period);
                    m_prev = m_period;
                    m_timeout = 1'b0;
                end
                m_armed = 1'b1;
                m_last = t;
            end else if (m_armed && (t - m_last) == TO) begin
                m_timeout = 1'b1; m_locked = 1'b0; m_armed = 1'b0; m_prev = 0;
            end
            m_sq = {m_sq[SS-2:0], bus.sig_in};
            m_sd = s;
        end
        s_hist[t] = s;
        t++;
    endtask

    task automatic compare();
        logic [31:0] exp_high;
`ifdef CLK_METER_DUTY_EN
        exp_high = m_high;
`else
        exp_high = 0;
`endif
        chk("period",    bus.period,       m_period);
        chk("high_time", bus.high_time,    exp_high);
        chk("valid",     bus.period_valid, m_pv);
        chk("locked",    bus.locked,       m_locked);
        chk("timeout",   bus.timeout,      m_timeout);
        if (bus.period_valid === 1'b1) pv_cnt++;
    endtask

    task automatic tick(input logic r, input logic e, input logic sg);
        rst = r; bus.en = e; bus.sig_in = sg;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic per(input int p, input int h, input int n);
        for (int i = 0; i < n; i++)
            for (int c = 0; c < p; c++) tick(1'b0, en_cur, c < h);
    endtask

    function automatic logic [31:0] hexp(input int h);
`ifdef CLK_METER_DUTY_EN
        return h;
`else
        return (h == h) ? 32'd0 : 32'd1;
`endif
    endfunction

    vec_t tbl [7];
    int   base;

    initial begin
        tbl[0] = '{10, 5, 4, 32'd10, hexp(5), 1'b1};
        tbl[1] = '{7, 3, 4, 32'd7, hexp(3), 1'b1};
        tbl[2] = '{9, 4, 4, 32'd9, hexp(4), 1'b1};
        tbl[3] = '{6, 3, 4, 32'd6, hexp(3), 1'b1};
        tbl[4] = '{13, 12, 4, 32'd13, hexp(12), 1'b1};
        tbl[5] = '{3, 2, 4, 32'd3, hexp(2), 1'b1};
        tbl[6] = '{16, 1, 4, 32'd16, hexp(1), 1'b1};

        rst = 1'b1; bus.en = 1'b0; bus.sig_in = 1'b0; en_cur = 1'b1;
        repeat (3) tick(1'b1, 1'b0, 1'b0);
        chk("rst_period",  bus.period, 0);
        chk("rst_high",    bus.high_time, 0);
        chk("rst_valid",   bus.period_valid, 0);
        chk("rst_locked",  bus.locked, 0);
        chk("rst_timeout", bus.timeout, 0);

        // table-driven steady-state patterns
        repeat (2) tick(1'b0, 1'b1, 1'b0);
        foreach (tbl[i]) begin
            per(tbl[i].p, tbl[i].h, tbl[i].n);
            repeat (3) tick(1'b0, 1'b1, 1'b0);
            chk("tbl_period", bus.period, tbl[i].exp_period);
            chk("tbl_high",   bus.high_time, tbl[i].exp_high);
            chk("tbl_locked", bus.locked, tbl[i].exp_locked);
            chk("tbl_tmo",    bus.timeout, 0);
        end

        // timeout: lock at 8, one more rise, then silence
        per(8, 4, 5);
        repeat (25) tick(1'b0, 1'b1, 1'b0);
        chk("tmo_flag",   bus.timeout, 1);
        chk("tmo_locked", bus.locked, 0);
        chk("tmo_period", bus.period, 8);
        per(8, 4, 2);
        chk("tmo_clear",  bus.timeout, 0);
        chk("tmo_resume", bus.period, 8);
        chk("tmo_nolock", bus.locked, 0);
        per(8, 4, 2);

        // boundary: period exactly TIMEOUT
        per(20, 10, 4);
        chk("bnd_period", bus.period, 20);
        chk("bnd_tmo",    bus.timeout, 0);
        chk("bnd_locked", bus.locked, 1);

        // enable drop mid-period
        per(6, 3, 4);
        tick(1'b0, 1'b1, 1'b1); tick(1'b0, 1'b1, 1'b1);
        en_cur = 1'b0;
        per(6, 3, 1);
        chk("en_unlock", bus.locked, 0);
        en_cur = 1'b1;
        base = pv_cnt;
        per(6, 3, 1);
        chk("en_nostrobe", pv_cnt - base, 0);
        per(6, 3, 3);
        chk("en_period", bus.period, 6);
        chk("en_locked", bus.locked, 1);

        // reset mid-period
        tick(1'b0, 1'b1, 1'b1); tick(1'b0, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b0);
        chk("mrst_period", bus.period, 0);
        chk("mrst_locked", bus.locked, 0);
        chk("mrst_tmo",    bus.timeout, 0);

        // minimum period 2: one strobe per period, never merged
        per(2, 1, 4);
        base = pv_cnt;
        per(2, 1, 10);
        chk("min_strobes", pv_cnt - base, 10);
        chk("min_period",  bus.period, 2);
        chk("min_locked",  bus.locked, 1);

        // randomized: periods up to 23 (some exceed TIMEOUT), rare enable dips
        for (int i = 0; i < 300; i++) begin
            int p, h;
            p = $urandom_range(2, 23);
            h = $urandom_range(1, p - 1);
            for (int c = 0; c < p; c++)
                tick(1'b0, ($urandom_range(0, 99) != 0), c < h);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
